// File: rtl/amuxbus_bbm_sequencer.sv
// Break-before-make sequencer for the AMUXBUS_A/AMUXBUS_B pad-ring buses.
// Each bus has its own round-robin arbiter and switch FSM, gated by a synchronized VDDA good.

// state | meaning
// IDLE  | all switches open, waiting for an eligible client while enabled
// MAKE  | owner's switch closed, settling before the grant is given
// CONN  | owner's switch closed and granted
// BRK   | all switches open, break-before-make gap before the next closure
module amuxbus_bbm_bus #(
  parameter int N_CLIENTS     = 4,
  parameter int BBM_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 en,
  input  logic [N_CLIENTS-1:0] req,
  input  logic [N_CLIENTS-1:0] elig,
  output logic [N_CLIENTS-1:0] sw,
  output logic [N_CLIENTS-1:0] gnt,
  output logic [N_CLIENTS-1:0] owned,
  output logic                 busy
);
  localparam int OW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  typedef enum logic [1:0] {IDLE, MAKE, CONN, BRK} state_t;

  state_t          state;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   ptr;
  logic [OW-1:0]   winner;
  logic [OW-1:0]   cand;
  logic            any_elig;
  logic [CNT_W-1:0] cnt;
  int              idx;

  function automatic logic [N_CLIENTS-1:0] onehot(input logic [OW-1:0] o);
    logic [N_CLIENTS-1:0] v;
    v    = '0;
    v[o] = 1'b1;
    return v;
  endfunction

  // Walk from farthest to nearest so the client closest above ptr is the last one kept.
  always_comb begin
    winner   = ptr;
    any_elig = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int k = N_CLIENTS; k >= 1; k--) begin
      idx  = (int'(ptr) + k) % N_CLIENTS;
      cand = OW'(idx);
      if (elig[cand]) begin
        winner   = cand;
        any_elig = 1'b1;
      end
    end
  end

  assign owned = (state != IDLE) ? onehot(owner) : '0;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= OW'(N_CLIENTS - 1);
      cnt   <= '0;
      sw    <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && any_elig) begin
            owner <= winner;
            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            sw    <= onehot(winner);
            busy  <= 1'b1;
            state <= MAKE;
          end
        end
        MAKE: begin
          if (!req[owner] || !en) begin
            cnt   <= CNT_W'(BBM_CYCLES - 1);
            sw    <= '0;
            state <= BRK;
          end else if (cnt == '0) begin
            ptr   <= owner;
            gnt   <= onehot(owner);
            state <= CONN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CONN: begin
          if (!req[owner] || !en) begin
            cnt   <= CNT_W'(BBM_CYCLES - 1);
            sw    <= '0;
            gnt   <= '0;
            state <= BRK;
          end
        end
        BRK: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          sw    <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

module amuxbus_bbm_sequencer #(
  parameter int N_CLIENTS     = 4,
  parameter int BBM_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 vdda_good,
  input  logic [N_CLIENTS-1:0] req_a,
  input  logic [N_CLIENTS-1:0] req_b,
  output logic [N_CLIENTS-1:0] sw_a,
  output logic [N_CLIENTS-1:0] sw_b,
  output logic [N_CLIENTS-1:0] gnt_a,
  output logic [N_CLIENTS-1:0] gnt_b,
  output logic                 busy_a,
  output logic                 busy_b
);
  logic                 vdda_meta;
  logic                 en_sync;
  logic [N_CLIENTS-1:0] owned_a;
  logic [N_CLIENTS-1:0] owned_b;
  logic [N_CLIENTS-1:0] elig_a;
  logic [N_CLIENTS-1:0] elig_b;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      vdda_meta <= 1'b0;
      en_sync   <= 1'b0;
    end else begin
      vdda_meta <= vdda_good;
      en_sync   <= vdda_meta;
    end
  end

  // A client asking for both buses is only offered bus A.
  assign elig_a = req_a & ~owned_b;
  assign elig_b = req_b & ~req_a & ~owned_a;

  amuxbus_bbm_bus #(
    .N_CLIENTS(N_CLIENTS), .BBM_CYCLES(BBM_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(CNT_W)
  ) u_bus_a (
    .clock(clock), .resetb(resetb), .en(en_sync), .req(req_a), .elig(elig_a),
    .sw(sw_a), .gnt(gnt_a), .owned(owned_a), .busy(busy_a)
  );

  amuxbus_bbm_bus #(
    .N_CLIENTS(N_CLIENTS), .BBM_CYCLES(BBM_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(CNT_W)
  ) u_bus_b (
    .clock(clock), .resetb(resetb), .en(en_sync), .req(req_b), .elig(elig_b),
    .sw(sw_b), .gnt(gnt_b), .owned(owned_b), .busy(busy_b)
  );
endmodule
